freq_meter_bcd: RTL and testbench
=================================

// Module: freq_meter_bcd
// PURPOSE
//   Fully synchronous, parametrised frequency meter. Counts rising edges of an
//   asynchronous input over a gate window, in a DIGITS-wide saturating BCD counter.
//   Three selectable gate ranges: 1 s, 100 ms, 10 ms.
//   Each gate result is latched with a decimal-point position and an overflow flag.
//   Sits between the raw pin and seg_decoder/seg_scan; nothing runs on sig_in as a clock.
// PARAMETERS
//   GATE_CYCLES  50_000_000  clk cycles in the 1 s gate; must be divisible by 100
//   DIGITS       6           BCD digits in counter and result (1..8)
//   SYNC_STAGES  2           synchroniser flops on sig_in (>=2)
// PORTS
//   clk        in   1          system clock; every flop is on its rising edge
//   rst        in   1          asynchronous, active-high reset
//   sig_in     in   1          signal to measure; asynchronous to clk
//   range_sel  in   2          0: 1 s gate, 1: 100 ms gate, 2/3: 10 ms gate
//   bcd_out    out  4*DIGITS   last result; digit 0 (units) in [3:0]
//   dp_pos     out  2          range used for bcd_out (0/1/2); seg_scan uses it for the decimal point
//   overflow   out  1          last result saturated
//   valid      out  1          one-cycle pulse when bcd_out/dp_pos/overflow update
//   blank_mask out  DIGITS     1 = leading-zero digit to blank (see CONFIGURATION)
// BEHAVIOUR
//   - Reset: all outputs 0; sync chain, edge register, gate counter and BCD count are 0.
//     Gate restarts at cycle 0 on release.
//   - Edge detect: sync[SYNC_STAGES-1] & ~prev.
//     A sig_in held high across reset release counts as one edge.
//     Maximum measurable rate is clk/2.
//   - Gate length: GLEN = GATE_CYCLES / 10^range, with range = min(range_sel, 2).
//     range_sel is sampled only on gate cycle 0; changes mid-gate take effect next gate.
//   - Gate counter width: $clog2(GATE_CYCLES).
//     Counts 0..GLEN-1, then wraps to 0 with no dead cycle.
//   - Counting: each edge increments the BCD count by 1.
//     Decade carries ripple combinationally within the same cycle.
//   - Saturation: an increment at all-9s leaves the count at all-9s and sets ovf_acc.
//   - Terminal cycle T (gate_cnt == GLEN-1): the edge of cycle T is included.
//     At the clk edge ending T: bcd_out <= count + edge_T, overflow <= ovf_acc | sat_T,
//     dp_pos <= range.
//     In the same clk edge: count <= 0, ovf_acc <= 0.
//   - An edge in cycle T+1 belongs to the next gate. No edge is lost or double counted.
//   - valid: high for exactly the cycle after T; low otherwise.
//     Results hold until the next terminal cycle.
//   - Reset mid-gate: partial count discarded; outputs cleared immediately (async).
//     First valid occurs GLEN+1 cycles after release.
// CONFIGURATION
//   - Macro FREQ_METER_LZ_BLANK_EN defined: blank_mask is registered together with bcd_out.
//     Bit i = 1 when digits DIGITS-1..i are all zero.
//     Bit 0 is always 0; it resets to 0.
//   - Macro undefined: blank_mask is constant 0; the port stays present.
// STRUCTURE
//   - Package freq_meter_pkg:
//     - typedef bcd_digit_t (logic [3:0])
//     - range enum RANGE_1S / RANGE_100MS / RANGE_10MS
//     - function gate_len(GATE_CYCLES, range)
//     - constant BCD_NINE
//   - Sub-module bcd_decade: one digit with inc_in, clr, digit, carry_out (digit==9 & inc_in).
//     Instantiated DIGITS times with a generate loop.
//     Saturation detect (all carries set) lives in the top level.
// TESTING (GATE_CYCLES=1000 unless noted)
//   1. range 0, sig_in period 10 clk -> bcd_out=0x000100, dp_pos=0, overflow=0,
//      valid pulses every 1000 cycles.
//   2. range 1, same input -> bcd_out=0x000010, dp_pos=1.
//      range_sel changed mid-gate -> old range applies until the next gate start.
//   3. DIGITS=2, period 4 clk, range 0 -> bcd_out=0x99, overflow=1.
//      Next gate with period 100 -> 0x10, overflow=0.
//   4. Single edges placed on cycle T and on cycle T+1 -> first result 1, next result 1.
//   5. rst pulsed at gate cycle 500 with input running -> outputs 0 at once.
//      valid next occurs 1001 cycles after release, with the full count.
//   6. Macro defined, count 42, DIGITS=6 -> blank_mask=6'b111100.
//      Count 0 -> 6'b111110. Macro undefined -> 0.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: shared types, gate-range decoding and BCD digit helpers
// used by freq_meter_bcd and its bcd_decade digit cells.
package freq_meter_pkg;

   typedef logic [3:0] bcd_digit_t;

   typedef enum logic [1:0] {
      RANGE_1S    = 2'd0,
      RANGE_100MS = 2'd1,
      RANGE_10MS  = 2'd2
   } range_e;

   localparam bcd_digit_t BCD_NINE = 4'd9;
   localparam bcd_digit_t BCD_ZERO = 4'd0;

   // Raw range select to gate range; codes 2 and 3 both select the 10 ms gate.
   function automatic range_e range_of(input logic [1:0] sel);
      range_e r;
      case (sel)
         2'd0:    r = RANGE_1S;
         2'd1:    r = RANGE_100MS;
         default: r = RANGE_10MS;
      endcase
      return r;
   endfunction

   // Gate length in clk cycles for a given range.
   function automatic int gate_len(input int gate_cycles, input range_e rng);
      int len;
      case (rng)
         RANGE_1S:    len = gate_cycles;
         RANGE_100MS: len = gate_cycles / 32'sd10;
         default:     len = gate_cycles / 32'sd100;
      endcase
      return len;
   endfunction

   // One decade step: +1 when inc is set, wrapping 9 -> 0.
   function automatic bcd_digit_t bcd_step(input bcd_digit_t d, input logic inc);
      bcd_digit_t r;
      if (!inc) begin
         r = d;
      end else if (d == BCD_NINE) begin
         r = BCD_ZERO;
      end else begin
         r = d + 4'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_decade.sv
// bcd_decade: one BCD digit of the edge counter. The digit steps when inc_in
// is high, holds while the whole counter is saturated and clears at the end
// of each gate. carry_out ripples combinationally into the next decade.
module bcd_decade
   import freq_meter_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       inc_in,
   input  logic       hold,
   input  logic       clr,
   output bcd_digit_t digit,
   output logic       carry_out
);

   bcd_digit_t digit_q;
   bcd_digit_t digit_d;

   // Next digit: gate-end clear wins, then saturation hold, else step.
   always_comb begin
      digit_d = digit_q;
      if (clr) begin
         digit_d = BCD_ZERO;
      end else if (hold) begin
         digit_d = digit_q;
      end else begin
         digit_d = bcd_step(digit_q, inc_in);
      end
   end

   // Digit register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         digit_q <= BCD_ZERO;
      end else begin
         digit_q <= digit_d;
      end
   end

   assign digit     = digit_q;
   assign carry_out = inc_in & (digit_q == BCD_NINE);

endmodule

// File: rtl/freq_meter_bcd.sv
// freq_meter_bcd: gated frequency meter. sig_in is synchronised and
// edge-detected in the clk domain; rising edges are counted in a DIGITS-wide
// saturating BCD counter over a 1 s / 100 ms / 10 ms gate. Each gate result
// is latched with its range (decimal point) and an overflow flag.
// Optional feature: define FREQ_METER_LZ_BLANK_EN to register a leading-zero
// blank mask alongside bcd_out; otherwise blank_mask is tied to zero.
module freq_meter_bcd
   import freq_meter_pkg::*;
#(
   parameter int GATE_CYCLES = 50_000_000,
   parameter int DIGITS      = 6,
   parameter int SYNC_STAGES = 2
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sig_in,
   input  logic [1:0]            range_sel,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic [1:0]            dp_pos,
   output logic                  overflow,
   output logic                  valid,
   output logic [DIGITS-1:0]     blank_mask
);

   localparam int CW = $clog2(GATE_CYCLES);

   // Last gate-counter value for each range.
   localparam logic [CW-1:0] LAST_1S    = CW'(gate_len(GATE_CYCLES, RANGE_1S) - 32'sd1);
   localparam logic [CW-1:0] LAST_100MS = CW'(gate_len(GATE_CYCLES, RANGE_100MS) - 32'sd1);
   localparam logic [CW-1:0] LAST_10MS  = CW'(gate_len(GATE_CYCLES, RANGE_10MS) - 32'sd1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic                   prev_q;
   logic                   prev_d;
   logic                   edge_s;

   logic [CW-1:0]          gate_cnt_q;
   logic [CW-1:0]          gate_cnt_d;
   logic [CW-1:0]          last_s;
   logic                   gate_start_s;
   logic                   terminal_s;
   range_e                 range_q;
   range_e                 range_d;
   range_e                 cur_range_s;

   logic [DIGITS:0]        carry_s;
   logic [4*DIGITS-1:0]    count_s;
   logic [4*DIGITS-1:0]    result_s;
   logic                   sat_s;

   logic                   ovf_acc_q;
   logic                   ovf_acc_d;
   logic [4*DIGITS-1:0]    bcd_out_q;
   logic [4*DIGITS-1:0]    bcd_out_d;
   logic [1:0]             dp_pos_q;
   logic [1:0]             dp_pos_d;
   logic                   overflow_q;
   logic                   overflow_d;
   logic                   valid_q;
   logic                   valid_d;

   // Synchroniser shift and single-cycle rising-edge detect on the last stage.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
      prev_d = sync_q[SYNC_STAGES-1];
      edge_s = sync_q[SYNC_STAGES-1] & ~prev_q;
   end

   // Gate timing: range is taken from range_sel only on gate cycle 0 and held
   // in range_q for the rest of the gate; the counter wraps with no dead cycle.
   always_comb begin
      gate_start_s = (gate_cnt_q == {CW{1'b0}});
      if (gate_start_s) begin
         cur_range_s = range_of(range_sel);
      end else begin
         cur_range_s = range_q;
      end
      case (cur_range_s)
         RANGE_1S:    last_s = LAST_1S;
         RANGE_100MS: last_s = LAST_100MS;
         default:     last_s = LAST_10MS;
      endcase
      terminal_s = (gate_cnt_q == last_s);
      if (terminal_s) begin
         gate_cnt_d = {CW{1'b0}};
      end else begin
         gate_cnt_d = gate_cnt_q + {{(CW-1){1'b0}}, 1'b1};
      end
      range_d = cur_range_s;
   end

   // Ripple-carry decade chain; carry out of the top decade means saturation.
   assign carry_s[0] = edge_s;

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_dec
         bcd_decade u_dec (
            .clk       (clk),
            .rst       (rst),
            .inc_in    (carry_s[gi]),
            .hold      (sat_s),
            .clr       (terminal_s),
            .digit     (count_s[4*gi +: 4]),
            .carry_out (carry_s[gi+1])
         );
      end
   endgenerate

   assign sat_s = carry_s[DIGITS];

   // Gate result: stored count plus this cycle's edge, pinned at all nines
   // when that edge would have wrapped the counter.
   always_comb begin
      result_s = count_s;
      for (int i = 0; i < DIGITS; i++) begin
         if (sat_s) begin
            result_s[4*i +: 4] = BCD_NINE;
         end else begin
            result_s[4*i +: 4] = bcd_step(count_s[4*i +: 4], carry_s[i]);
         end
      end
   end

   // Overflow accumulation and output latching on the terminal gate cycle.
   always_comb begin
      valid_d = terminal_s;
      if (terminal_s) begin
         ovf_acc_d  = 1'b0;
         bcd_out_d  = result_s;
         dp_pos_d   = cur_range_s;
         overflow_d = ovf_acc_q | sat_s;
      end else begin
         ovf_acc_d  = ovf_acc_q | sat_s;
         bcd_out_d  = bcd_out_q;
         dp_pos_d   = dp_pos_q;
         overflow_d = overflow_q;
      end
   end

   // Synchroniser, gate and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q     <= {SYNC_STAGES{1'b0}};
         prev_q     <= 1'b0;
         gate_cnt_q <= {CW{1'b0}};
         range_q    <= RANGE_1S;
         ovf_acc_q  <= 1'b0;
         bcd_out_q  <= {(4*DIGITS){1'b0}};
         dp_pos_q   <= 2'd0;
         overflow_q <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         sync_q     <= sync_d;
         prev_q     <= prev_d;
         gate_cnt_q <= gate_cnt_d;
         range_q    <= range_d;
         ovf_acc_q  <= ovf_acc_d;
         bcd_out_q  <= bcd_out_d;
         dp_pos_q   <= dp_pos_d;
         overflow_q <= overflow_d;
         valid_q    <= valid_d;
      end
   end

   assign bcd_out  = bcd_out_q;
   assign dp_pos   = dp_pos_q;
   assign overflow = overflow_q;
   assign valid    = valid_q;

`ifdef FREQ_METER_LZ_BLANK_EN
   logic [DIGITS-1:0] blank_q;
   logic [DIGITS-1:0] blank_d;
   logic [DIGITS-1:0] blank_next_s;
   logic              zero_run_s;

   // Leading-zero mask of the gate result: bit i set when digits DIGITS-1..i
   // are all zero; the units digit is never blanked.
   always_comb begin
      blank_next_s = {DIGITS{1'b0}};
      zero_run_s   = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zero_run_s      = zero_run_s & (result_s[4*i +: 4] == BCD_ZERO);
         blank_next_s[i] = zero_run_s;
      end
      blank_next_s[0] = 1'b0;
      if (terminal_s) begin
         blank_d = blank_next_s;
      end else begin
         blank_d = blank_q;
      end
   end

   // Blank mask register, updated with bcd_out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blank_q <= {DIGITS{1'b0}};
      end else begin
         blank_q <= blank_d;
      end
   end

   assign blank_mask = blank_q;
`else
   assign blank_mask = {DIGITS{1'b0}};
`endif

endmodule

// File: tb/tb_freq_meter_bcd.sv
// tb_freq_meter_bcd: randomized bench for freq_meter_bcd (GATE_CYCLES=1000).
// Two instances (DIGITS=6 and DIGITS=2) see the same stimulus. The reference
// model records the value driven on every clock, derives the rising edges,
// splits time into gates from the range seen at each gate start, and counts
// edges per gate with prefix sums.
module tb_freq_meter_bcd;

   localparam int GC   = 1000;
   localparam int SS   = 2;
   localparam int MAXC = 4096;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sig_in = 1'b0;
   logic [1:0]  range_sel = 2'd0;

   logic [23:0] bcd6;
   logic [1:0]  dp6;
   logic        ovf6;
   logic        val6;
   logic [5:0]  blk6;
   logic [7:0]  bcd2;
   logic [1:0]  dp2;
   logic        ovf2;
   logic        val2;
   logic [1:0]  blk2;

   always #5 clk = ~clk;

   freq_meter_bcd #(.GATE_CYCLES(GC), .DIGITS(6), .SYNC_STAGES(SS)) u_dut6 (
      .clk(clk), .rst(rst), .sig_in(sig_in), .range_sel(range_sel),
      .bcd_out(bcd6), .dp_pos(dp6), .overflow(ovf6), .valid(val6), .blank_mask(blk6)
   );

   freq_meter_bcd #(.GATE_CYCLES(GC), .DIGITS(2), .SYNC_STAGES(SS)) u_dut2 (
      .clk(clk), .rst(rst), .sig_in(sig_in), .range_sel(range_sel),
      .bcd_out(bcd2), .dp_pos(dp2), .overflow(ovf2), .valid(val2), .blank_mask(blk2)
   );

   typedef struct {
      int          idx;
      logic        v6;
      logic        v2;
      logic [23:0] b6;
      logic [1:0]  d6;
      logic        o6;
      logic [5:0]  k6;
      logic [7:0]  b2;
      logic [1:0]  d2;
      logic        o2;
      logic [1:0]  k2;
   } obs_t;

   obs_t       obs_q[$];
   logic       sig_hist [0:MAXC-1];
   logic [1:0] rng_hist [0:MAXC-1];
   int         cum      [0:MAXC-1];
   int         n = 0;
   int         checks = 0;
   int         errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] to_bcd(input int v, input int d);
      logic [31:0] r;
      int          x;
      r = 32'd0;
      x = v;
      for (int i = 0; i < d; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic [31:0] exp_blank(input logic [31:0] bcd, input int d);
      logic [31:0] m;
      m = 32'd0;
`ifdef FREQ_METER_LZ_BLANK_EN
      for (int i = 1; i < d; i++) begin
         if ((bcd >> (4*i)) == 32'd0) m[i] = 1'b1;
      end
`else
      if (d < 0) m = bcd;
`endif
      return m;
   endfunction

   // Record every valid pulse with the clock index it follows.
   always @(posedge clk) begin : mon
      obs_t o;
      #1;
      if (!rst && (val6 || val2)) begin
         o.idx = n;  o.v6 = val6; o.v2 = val2;
         o.b6 = bcd6; o.d6 = dp6; o.o6 = ovf6; o.k6 = blk6;
         o.b2 = bcd2; o.d2 = dp2; o.o2 = ovf2; o.k2 = blk2;
         obs_q.push_back(o);
      end
   end

   // Drive values for the next rising edge, log them, wait for the following negedge.
   task automatic drive(input logic s, input logic [1:0] r);
      sig_in    = s;
      range_sel = r;
      if (n < MAXC - 1) n++;
      sig_hist[n] = s;
      rng_hist[n] = r;
      @(negedge clk);
   endtask

   // Assert reset between edges, check the async clear, release at a negedge.
   task automatic do_reset(input logic s_hold);
      #2;
      rst    = 1'b1;
      sig_in = s_hold;
      #1;
      check_eq("rst bcd6",  32'(bcd6), 32'd0);
      check_eq("rst dp6",   32'(dp6),  32'd0);
      check_eq("rst ovf6",  32'(ovf6), 32'd0);
      check_eq("rst val6",  32'(val6), 32'd0);
      check_eq("rst blk6",  32'(blk6), 32'd0);
      check_eq("rst bcd2",  32'(bcd2), 32'd0);
      check_eq("rst ovf2",  32'(ovf2), 32'd0);
      check_eq("rst val2",  32'(val2), 32'd0);
      repeat (3) @(negedge clk);
      obs_q.delete();
      n           = 0;
      sig_hist[0] = 1'b0;
      rng_hist[0] = 2'd0;
      rst         = 1'b0;
   endtask

   function automatic logic pat(input int c, input int per, input int ph);
      return ((c + ph) % per) < (per / 2);
   endfunction

   task automatic run_seg(input int len, input int per_a, input int per_b, input int sw_per,
                          input logic [1:0] rng_a, input logic [1:0] rng_b, input int sw_rng,
                          input int ph);
      for (int c = 1; c <= len; c++) begin
         drive(pat(c, (c < sw_per) ? per_a : per_b, ph), (c < sw_rng) ? rng_a : rng_b);
      end
   endtask

   // Build expected gate results from the logged stimulus and compare.
   task automatic finish_segment(input string nm);
      int start, gi, r, glen, stop, cnt, c6, c2;
      obs_t o;
      logic [31:0] e6, e2;
      cum[0] = 0;
      for (int e = 1; e <= n; e++) begin
         cum[e] = cum[e-1];
         if (e - SS >= 1) begin
            if (sig_hist[e-SS] && !sig_hist[e-SS-1]) cum[e] = cum[e] + 1;
         end
      end
      start = 0;
      gi    = 0;
      while (start + 1 <= n) begin
         r    = (rng_hist[start+1] > 2'd2) ? 2 : int'(rng_hist[start+1]);
         glen = GC / ((r == 0) ? 1 : (r == 1) ? 10 : 100);
         stop = start + glen;
         if (stop > n) break;
         cnt = cum[stop] - cum[start];
         c6  = (cnt > 999999) ? 999999 : cnt;
         c2  = (cnt > 99) ? 99 : cnt;
         e6  = to_bcd(c6, 6);
         e2  = to_bcd(c2, 2);
         if (gi < obs_q.size()) begin
            o = obs_q[gi];
            check_eq($sformatf("%s g%0d idx", nm, gi),  32'(o.idx), 32'(stop));
            check_eq($sformatf("%s g%0d vld", nm, gi),  {30'd0, o.v6, o.v2}, 32'd3);
            check_eq($sformatf("%s g%0d bcd6", nm, gi), 32'(o.b6), e6);
            check_eq($sformatf("%s g%0d ovf6", nm, gi), 32'(o.o6), 32'(cnt > 999999));
            check_eq($sformatf("%s g%0d dp6", nm, gi),  32'(o.d6), 32'(r));
            check_eq($sformatf("%s g%0d blk6", nm, gi), 32'(o.k6), exp_blank(e6, 6));
            check_eq($sformatf("%s g%0d bcd2", nm, gi), 32'(o.b2), e2);
            check_eq($sformatf("%s g%0d ovf2", nm, gi), 32'(o.o2), 32'(cnt > 99));
            check_eq($sformatf("%s g%0d dp2", nm, gi),  32'(o.d2), 32'(r));
            check_eq($sformatf("%s g%0d blk2", nm, gi), 32'(o.k2), exp_blank(e2, 2));
         end
         gi++;
         start = stop;
      end
      check_eq({nm, " nvalid"}, 32'(obs_q.size()), 32'(gi));
   endtask

   initial begin
      do_reset(1'b0);

      // Period 10, 1 s gate: 100 edges per gate (DIGITS=2 saturates).
      run_seg(3100, 10, 10, 0, 2'd0, 2'd0, 0, 0);
      finish_segment("p10r0");
      do_reset(1'b1);

      // 100 ms gate, range_sel switched mid-gate to 1 s.
      run_seg(1500, 10, 10, 0, 2'd1, 2'd0, 150, 3);
      finish_segment("p10r1sw");
      do_reset(1'b0);

      // Period 4 then period 100 from the second gate.
      run_seg(2100, 4, 100, 1000, 2'd0, 2'd0, 0, 0);
      finish_segment("p4p100");
      do_reset(1'b0);

      // Single edges landing on the terminal cycle and just after one.
      for (int c = 1; c <= 3100; c++) begin
         drive((c == 998) || (c == 1999), 2'd0);
      end
      finish_segment("tedge");
      do_reset(1'b1);

      // Input running, reset in the middle of a gate, then a full gate.
      run_seg(1500, 7, 7, 0, 2'd0, 2'd0, 0, 1);
      finish_segment("mid1");
      do_reset(1'b1);
      run_seg(1100, 7, 7, 0, 2'd0, 2'd0, 0, 1);
      finish_segment("mid2");
      do_reset(1'b0);

      // Randomized segments: rates up to clk/2, all range codes, mid-gate changes.
      for (int s = 0; s < 8; s++) begin
         run_seg($urandom_range(800, 3000),
                 $urandom_range(2, 60), $urandom_range(2, 60), $urandom_range(1, 3000),
                 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom_range(1, 3000),
                 $urandom_range(0, 59));
         finish_segment($sformatf("rnd%0d", s));
         do_reset(1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
